// File: rtl/ecc_pkg.sv
// Shared types and helpers for the SECDED stream encoder.
// calc_m returns the Hamming check-bit count for a given data width.
package ecc_pkg;

  typedef enum logic [1:0] {
    INJ_NONE   = 2'd0,
    INJ_SINGLE = 2'd1,
    INJ_DOUBLE = 2'd2
  } inj_mode_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  typedef enum logic {
    INJ_IDLE  = 1'b0,
    INJ_ARMED = 1'b1
  } inj_state_t;

  // Smallest m with 2**m >= m + k + 1.
  function automatic int calc_m(input int k);
    int m;
    m = 1;
    while ((1 << m) < (m + k + 1)) m++;
    return m;
  endfunction

endpackage

// File: rtl/ecc_secded_lane_enc.sv
// Combinational extended-Hamming encoder for one lane: K data bits in,
// CW = n+1 codeword bits out, with the overall parity bit at LSB or MSB.
module ecc_secded_lane_enc
  import ecc_pkg::*;
#(
  parameter int K      = 26,
  parameter bit P0_LSB = 1'b1,
  localparam int M     = calc_m(K),
  localparam int N     = M + K,
  localparam int CW    = N + 1
) (
  input  logic [K-1:0]  d_i,
  output logic [CW-1:0] q_o
);

  // Positions covered by check bit b (data positions only).
  function automatic logic [N:1] cover_mask(input int b);
    logic [N:1] mask;
    mask = '0;
    for (int p = 1; p <= N; p++) begin
      if ((((p >> b) & 1) == 1) && ((p & (p - 1)) != 0)) mask[p] = 1'b1;
    end
    return mask;
  endfunction

  logic [N:1]   dpos;
  logic [N:1]   cw;
  logic [M-1:0] par;
  logic         p0;

  // Data occupies the non-power-of-two positions in ascending order.
  for (genvar gi = 1; gi <= N; gi++) begin : g_pos
    if ((gi & (gi - 1)) != 0) begin : g_data
      assign dpos[gi] = d_i[gi - $clog2(gi + 1) - 1];
      assign cw[gi]   = dpos[gi];
    end else begin : g_check
      assign dpos[gi] = 1'b0;
      assign cw[gi]   = par[$clog2(gi)];
    end
  end

  for (genvar gi = 0; gi < M; gi++) begin : g_parity
    localparam logic [N:1] COVER = cover_mask(gi);
    assign par[gi] = ^(dpos & COVER);
  end

  assign p0 = ^cw;

  if (P0_LSB) begin : g_p0_lsb
    assign q_o = {cw, p0};
  end else begin : g_p0_msb
    assign q_o = {p0, cw};
  end

endmodule

// File: rtl/ecc_secded_stream_enc.sv
// Multi-lane SECDED stream encoder: one output register plus one skid entry,
// one-shot single/double bit error injection and a saturating beat counter.
module ecc_secded_stream_enc
  import ecc_pkg::*;
#(
  parameter int K       = 26,
  parameter int LANES   = 2,
  parameter bit P0_LSB  = 1'b1,
  parameter int CNT_W   = 32,
  localparam int M      = calc_m(K),
  localparam int CW     = M + K + 1,
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int PW     = $clog2(CW)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic [LANES*K-1:0]  d_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [LANES*CW-1:0] q_o,
  output logic                valid_o,
  input  logic                ready_i,
  input  logic                inj_req_i,
  input  logic [1:0]          inj_mode_i,
  input  logic [LW-1:0]       inj_lane_i,
  input  logic [PW-1:0]       inj_pos_i,
  output logic                inj_done_o,
  output logic [CNT_W-1:0]    cnt_o
);

  logic [LANES*CW-1:0] enc_raw;
  logic [LANES*CW-1:0] enc_inj;
  logic [LANES*CW-1:0] inj_mask;
  logic [LANES*CW-1:0] q_reg;
  logic [LANES*CW-1:0] skid_q_reg;
  logic                valid_reg;
  logic                ready_reg;
  logic [CNT_W-1:0]    cnt_reg;

  skid_state_t skid_reg, skid_next;
  inj_state_t  inj_reg, inj_next;

  logic          acc, xfer;
  logic          load_out_in, load_out_skid, load_skid;
  logic          arm_req, inj_fire, flip_en;
  logic          inj_dbl_reg;
  logic [LW-1:0] inj_lane_reg;
  logic [PW-1:0] inj_pos_reg;
  logic [PW-1:0] pos_next;

  assign acc     = valid_i && ready_reg;
  assign xfer    = valid_reg && ready_i;
  assign arm_req = inj_req_i && ((inj_mode_i == INJ_SINGLE) || (inj_mode_i == INJ_DOUBLE));

  // Injection mask built from the captured request; out-of-range targets flip nothing.
  assign pos_next = (int'(inj_pos_reg) == CW - 1) ? '0 : inj_pos_reg + 1'b1;
  assign flip_en  = (int'(inj_pos_reg) < CW) && (int'(inj_lane_reg) < LANES);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    ecc_secded_lane_enc #(
      .K      (K),
      .P0_LSB (P0_LSB)
    ) u_lane_enc (
      .d_i (d_i[gi*K +: K]),
      .q_o (enc_raw[gi*CW +: CW])
    );
    for (genvar gj = 0; gj < CW; gj++) begin : g_bit
      assign inj_mask[gi*CW + gj] = flip_en && (int'(inj_lane_reg) == gi) &&
                                    ((int'(inj_pos_reg) == gj) ||
                                     (inj_dbl_reg && (int'(pos_next) == gj)));
    end
  end

  assign enc_inj = enc_raw ^ (inj_fire ? inj_mask : '0);

  // Skid FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) skid_reg <= SKID_EMPTY;
    else       skid_reg <= skid_next;
  end

  // Skid FSM: next state
  always_comb begin
    skid_next = skid_reg;
    unique case (skid_reg)
      SKID_EMPTY: if (acc) skid_next = SKID_ONE;
      SKID_ONE: begin
        if (acc && !xfer)      skid_next = SKID_TWO;
        else if (!acc && xfer) skid_next = SKID_EMPTY;
      end
      SKID_TWO:   if (xfer) skid_next = SKID_ONE;
      default:    skid_next = SKID_EMPTY;
    endcase
  end

  // Skid FSM: datapath load enables
  always_comb begin
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (skid_reg)
      SKID_EMPTY: load_out_in = acc;
      SKID_ONE: begin
        load_out_in = acc && xfer;
        load_skid   = acc && !xfer;
      end
      SKID_TWO:   load_out_skid = xfer;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_reg      <= '0;
      skid_q_reg <= '0;
      valid_reg  <= 1'b0;
      ready_reg  <= 1'b0;
    end else begin
      if (load_out_in)        q_reg <= enc_inj;
      else if (load_out_skid) q_reg <= skid_q_reg;
      if (load_skid)          skid_q_reg <= enc_inj;
      valid_reg <= (skid_next != SKID_EMPTY);
      ready_reg <= (skid_next != SKID_TWO);
    end
  end

  // Injection FSM: state register and request capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inj_reg      <= INJ_IDLE;
      inj_dbl_reg  <= 1'b0;
      inj_lane_reg <= '0;
      inj_pos_reg  <= '0;
    end else begin
      inj_reg <= inj_next;
      if ((inj_reg == INJ_IDLE) && arm_req && !clear_i) begin
        inj_dbl_reg  <= (inj_mode_i == INJ_DOUBLE);
        inj_lane_reg <= inj_lane_i;
        inj_pos_reg  <= inj_pos_i;
      end
    end
  end

  // Injection FSM: next state (clear wins over arm and over completion)
  always_comb begin
    inj_next = inj_reg;
    unique case (inj_reg)
      INJ_IDLE:  if (arm_req && !clear_i) inj_next = INJ_ARMED;
      INJ_ARMED: if (clear_i || acc)      inj_next = INJ_IDLE;
      default:   inj_next = INJ_IDLE;
    endcase
  end

  // Injection FSM: outputs
  always_comb begin
    inj_fire   = (inj_reg == INJ_ARMED) && !clear_i;
    inj_done_o = inj_fire && acc;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                       cnt_reg <= '0;
    else if (clear_i)                cnt_reg <= '0;
    else if (xfer && (cnt_reg != '1)) cnt_reg <= cnt_reg + 1'b1;
  end

  assign ready_o = ready_reg;
  assign valid_o = valid_reg;
  assign q_o     = q_reg;
  assign cnt_o   = cnt_reg;

endmodule

// File: tb/tb_ecc_secded_stream_enc.sv
// Directed and soak bench for ecc_secded_stream_enc (K=26, LANES=2, P0_LSB=1, CW=32).
// Hand-computed codewords for the directed beats, an independent encoder/decoder for the soak.
module tb_ecc_secded_stream_enc;

  localparam int K     = 26;
  localparam int LANES = 2;
  localparam int CW    = 32;
  localparam int CNT_W = 32;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                clear_i;
  logic [LANES*K-1:0]  d_i;
  logic                valid_i;
  logic                ready_o;
  logic [LANES*CW-1:0] q_o;
  logic                valid_o;
  logic                ready_i;
  logic                inj_req_i;
  logic [1:0]          inj_mode_i;
  logic                inj_lane_i;
  logic [4:0]          inj_pos_i;
  logic                inj_done_o;
  logic [CNT_W-1:0]    cnt_o;

  ecc_secded_stream_enc #(
    .K      (K),
    .LANES  (LANES),
    .P0_LSB (1'b1),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .d_i        (d_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .q_o        (q_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .inj_req_i  (inj_req_i),
    .inj_mode_i (inj_mode_i),
    .inj_lane_i (inj_lane_i),
    .inj_pos_i  (inj_pos_i),
    .inj_done_o (inj_done_o),
    .cnt_o      (cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] q;
    int          kind;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   out_n  = 0;
  bit   s_acc;
  bit   model_armed = 1'b0;
  bit   m_dbl;
  int   m_lane, m_pos;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference encoder: data filled in order into non-power-of-two positions.
  function automatic logic [31:0] ref_enc(input logic [25:0] d);
    logic [31:0] cw;
    logic        par;
    int          j;
    cw = '0;
    j  = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[j];
        j++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      par = 1'b0;
      for (int p = 1; p < 32; p++) if (((p >> i) & 1) == 1) par ^= cw[p];
      cw[1 << i] = par;
    end
    cw[0] = ^cw[31:1];
    return cw;
  endfunction

  function automatic logic [63:0] ref_mask(input int lane, input int pos, input bit dbl);
    logic [63:0] mk;
    mk = '0;
    mk[lane*32 + pos] = 1'b1;
    if (dbl) mk[lane*32 + ((pos + 1) % 32)] = 1'b1;
    return mk;
  endfunction

  // 0 clean, 1 correctable single, 2 detected double (worst lane wins).
  function automatic int classify(input logic [63:0] q);
    int          cls;
    int          syn;
    logic [31:0] w;
    cls = 0;
    for (int l = 0; l < 2; l++) begin
      w   = q[l*32 +: 32];
      syn = 0;
      for (int p = 1; p < 32; p++) if (w[p]) syn ^= p;
      if (^w) begin
        if (cls < 1) cls = 1;
      end else if (syn != 0) begin
        cls = 2;
      end
    end
    return cls;
  endfunction

  // Inputs are set just after a rising edge; handshakes are evaluated here before the next one.
  task automatic tick();
    exp_t e;
    bit   acc, xfer, armed;
    #1;
    acc   = valid_i && ready_o;
    xfer  = valid_o && ready_i;
    armed = model_armed && !clear_i;
    s_acc = acc;
    if (xfer) begin
      out_n++;
      $display("beat %0d out q=%h cnt=%0d", out_n, q_o, cnt_o);
      if (exp_q.size() == 0) begin
        check("q_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("q", q_o, e.q);
        check("dec_class", classify(q_o), e.kind);
      end
    end
    if (acc) begin
      e.q    = {ref_enc(d_i[51:26]), ref_enc(d_i[25:0])};
      e.kind = 0;
      if (armed) begin
        e.q    = e.q ^ ref_mask(m_lane, m_pos, m_dbl);
        e.kind = m_dbl ? 2 : 1;
      end
      exp_q.push_back(e);
      check("inj_done", inj_done_o, armed);
    end
    if (clear_i) model_armed = 1'b0;
    else if (armed && acc) model_armed = 1'b0;
    else if (!model_armed && inj_req_i && (inj_mode_i == 2'd1 || inj_mode_i == 2'd2)) begin
      model_armed = 1'b1;
      m_lane      = int'(inj_lane_i);
      m_pos       = int'(inj_pos_i);
      m_dbl       = (inj_mode_i == 2'd2);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [51:0] d);
    int n;
    valid_i = 1'b1;
    d_i     = d;
    n       = 0;
    s_acc   = 1'b0;
    while (!s_acc && n < 100) begin
      tick();
      n++;
    end
    if (!s_acc) check("send_timeout", 64'd0, 64'd1);
    valid_i = 1'b0;
  endtask

  task automatic arm(input logic [1:0] mode, input logic lane, input logic [4:0] pos);
    inj_req_i  = 1'b1;
    inj_mode_i = mode;
    inj_lane_i = lane;
    inj_pos_i  = pos;
    tick();
    inj_req_i  = 1'b0;
  endtask

  initial begin
    logic [63:0] rnd;
    int          sent, cyc, base;

    rst_i = 1'b1; clear_i = 1'b0; d_i = '0; valid_i = 1'b0; ready_i = 1'b0;
    inj_req_i = 1'b0; inj_mode_i = 2'd0; inj_lane_i = 1'b0; inj_pos_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ready", ready_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_q", q_o, 0);
    check("rst_cnt", cnt_o, 0);
    check("rst_done", inj_done_o, 0);
    rst_i = 1'b0;
    check("rel_ready_low", ready_o, 0);
    tick();
    check("rel_ready_high", ready_o, 1);

    // Basic encode, one-cycle latency
    ready_i = 1'b1;
    send({26'd0, 26'd1});
    check("enc_valid", valid_o, 1);
    check("enc_q", q_o, {32'h0000_0000, 32'h0000_000F});
    tick();
    check("enc_cnt", cnt_o, 1);

    // Clear then backpressure with three beats
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clear_cnt", cnt_o, 0);
    ready_i = 1'b0;
    send({26'd2, 26'd1});
    send({26'd0, 26'h3FF_FFFF});
    check("bp_ready_full", ready_o, 0);
    valid_i = 1'b1;
    d_i     = {26'h155_5555, 26'h0AA_AAAA};
    tick();
    tick();
    check("bp_ready_hold", ready_o, 0);
    check("bp_q_hold", q_o, {32'h0000_0033, 32'h0000_000F});
    ready_i = 1'b1;
    tick();
    check("bp_ready_back", ready_o, 1);
    send({26'h155_5555, 26'h0AA_AAAA});
    tick();
    check("bp_cnt", cnt_o, 3);
    check("bp_empty", valid_o, 0);

    // Single injection on lane 0 bit 0, then a clean beat
    arm(2'd1, 1'b0, 5'd0);
    send({26'd0, 26'd1});
    check("inj1_q", q_o, {32'h0000_0000, 32'h0000_000E});
    send({26'd0, 26'd1});
    check("inj1_next_clean", q_o, {32'h0000_0000, 32'h0000_000F});

    // Double injections, including wrap from bit 31 to bit 0, and lane 1
    arm(2'd2, 1'b0, 5'd4);
    send({26'd0, 26'd1});
    check("inj2_q", q_o, {32'h0000_0000, 32'h0000_003F});
    arm(2'd2, 1'b0, 5'd31);
    send({26'd0, 26'd0});
    check("inj2_wrap_q", q_o, {32'h0000_0000, 32'h8000_0001});
    arm(2'd1, 1'b1, 5'd5);
    send({26'd2, 26'd0});
    check("inj1_lane1_q", q_o, {32'h0000_0013, 32'h0000_0000});
    arm(2'd3, 1'b0, 5'd0);
    send({26'd0, 26'd1});
    check("inj_reserved_q", q_o, {32'h0000_0000, 32'h0000_000F});
    tick();

    // Reset mid-traffic discards buffered beats
    ready_i = 1'b0;
    send({26'd7, 26'd9});
    send({26'd11, 26'd13});
    rst_i = 1'b1;
    #1;
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_ready", ready_o, 0);
    check("mid_rst_cnt", cnt_o, 0);
    exp_q.delete();
    model_armed = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("mid_rel_ready_low", ready_o, 0);
    tick();
    check("mid_rel_ready_high", ready_o, 1);
    ready_i = 1'b1;
    send({26'd0, 26'd1});
    check("mid_post_q", q_o, {32'h0000_0000, 32'h0000_000F});
    tick();
    check("mid_post_cnt", cnt_o, 1);

    // Random soak with occasional injections
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    base = out_n;
    sent = 0;
    cyc  = 0;
    while ((out_n - base) < 10000 && cyc < 60000) begin
      valid_i    = (sent < 10000) && ($urandom_range(0, 3) != 0);
      rnd        = {$urandom(), $urandom()};
      d_i        = rnd[51:0];
      ready_i    = ($urandom_range(0, 3) != 0);
      inj_req_i  = !model_armed && ($urandom_range(0, 39) == 0);
      inj_mode_i = 2'($urandom_range(1, 2));
      inj_lane_i = 1'($urandom_range(0, 1));
      inj_pos_i  = 5'($urandom_range(0, 31));
      tick();
      if (s_acc) sent++;
      cyc++;
    end
    valid_i   = 1'b0;
    inj_req_i = 1'b0;
    if (cyc >= 60000) check("soak_timeout", 64'd0, 64'd1);
    check("soak_cnt", cnt_o, 10000);
    check("soak_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
